multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM that sequences the shared single-ALU, single-memory RISC-V datapath. It fetches through a ready/valid memory port, decodes the opcode held in the datapath's instruction register, and steps ALU, register-file, memory and PC strobes across cycles. It supports ADD/SUB/AND/OR, ADDI, LW, SW, BEQ and BNE. It replaces single-cycle control when the datapath is folded onto one ALU and one unified memory.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag, valid in the cycle it is sampled
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write request (SW data phase only)
- adr_src  out  1  memory address: 0 = PC, 1 = ALU result register
- ir_write  out  1  latch fetched word into IR and old-PC
- pc_write  out  1  update PC this cycle
- pc_src  out  1  PC source: 0 = PC+4, 1 = old-PC + immediate
- reg_write  out  1  register-file write enable
- result_src  out  1  writeback: 0 = ALU result, 1 = memory data
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or
- imm_src  out  2  00 I-type, 01 S-type, 10 B-type
- illegal  out  1  sticky trap flag
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP.
- FETCH: drives mem_req=1 and adr_src=0, and waits while mem_ready=0. When mem_ready=1, drives ir_write=1, pc_write=1 and pc_src=0, then moves to DECODE.
- DECODE: no strobes. Next state by opcode:
  - 0110011 goes to EXEC_R.
  - 0010011 with funct3=000 goes to EXEC_I.
  - 0000011 with funct3=010 goes to MEM_ADR.
  - 0100011 with funct3=010 goes to MEM_ADR.
  - 1100011 with funct3 000 or 001 goes to BRANCH.
  - Anything else goes to TRAP.
- EXEC_R: alu_src=0. The alu_ctrl mapping is:
  - funct3 000 with funct7_5=0 gives add; with funct7_5=1 gives sub.
  - funct3 111 gives and; funct3 110 gives or.
  - Other funct3 values are caught in DECODE and go to TRAP.
  - Then moves to WB_ALU.
- EXEC_I: alu_src=1, imm_src=00, alu_ctrl=000, then moves to WB_ALU.
- WB_ALU: reg_write=1, result_src=0, then moves to FETCH (retire).
- MEM_ADR: alu_src=1, alu_ctrl=000. imm_src is 00 for LW and 01 for SW. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, adr_src=1, mem_we=0. Waits for mem_ready, then moves to WB_MEM.
- WB_MEM: reg_write=1, result_src=1, then moves to FETCH (retire).
- MEM_WR: mem_req=1, mem_we=1, adr_src=1. Waits for mem_ready, then moves to FETCH (retire).
- BRANCH: alu_src=0, alu_ctrl=001, imm_src=10, pc_src=1. pc_write is set as follows:
  - BEQ (funct3 000): pc_write = zero.
  - BNE (funct3 001): pc_write = ~zero.
  - Moves to FETCH (retire).
- TRAP: illegal=1 and all strobes 0. The FSM stays in TRAP until rst.
- Unlisted outputs are 0 in every state.
- instr_count increments by 1 on each retiring transition. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset (async, immediate): state=FETCH, instr_count=0, illegal=0, all strobes 0.
- Outputs depend on state and inputs as follows:
  - In FETCH, ir_write and pc_write equal mem_ready.
  - In BRANCH, pc_write depends on zero combinationally.
  - All other outputs are Moore (depend on state only).
- mem_req must not drop while a request is pending. Only mem_ready or rst ends it. A request held for N wait cycles keeps adr_src and mem_we stable throughout.
- Latency with mem_ready tied 1:
  - BEQ/BNE: 3 cycles.
  - ADDI, R-type, SW: 4 cycles.
  - LW: 5 cycles.
  - Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- rst asserted mid-request drops mem_req in the same cycle. No writeback occurs after reset.
- An illegal opcode is detected in DECODE. TRAP is entered on the next edge, and the illegal instruction does not increment instr_count.

## Structure
- Package ctrl_pkg holds:
  - the state enum;
  - opcode localparams (OP_R, OP_ADDI, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALU_ADD/SUB/AND/OR;
  - IMM_I/S/B.
- Sub-module alu_decoder: combinational. Maps {funct3, funct7_5} to alu_ctrl plus a legal flag for R-type. It is instantiated once; DECODE uses its legal flag.
- The main module holds the state register, next-state logic, output decode and the counter.

## Test plan
- ADDI (opcode 0010011), mem_ready=1: the state sequence is FETCH, DECODE, EXEC_I, WB_ALU, FETCH. reg_write=1 for exactly one cycle, and instr_count goes 0 to 1.
- LW with mem_ready low for 3 cycles in MEM_RD: mem_req and adr_src=1 stay high for 4 cycles, WB_MEM follows with result_src=1, and total latency is 8 cycles.
- BNE with zero=0: pc_write=1 and pc_src=1 in BRANCH. Repeated with zero=1: pc_write=0. BEQ gives the inverse results.
- R-type with funct3=000 and funct7_5=1: alu_ctrl=001. With funct3=001: TRAP, illegal=1, and the FSM is still in TRAP 10 cycles later with all strobes 0.
- Assert rst while in FETCH with mem_ready=0 and mem_req=1: mem_req drops before the next edge. After release, FETCH resumes and instr_count=0.
- With CNT_W=4, retire 17 ADDIs: instr_count holds at 15.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control FSM.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADR,
        MEM_RD,
        MEM_WR,
        WB_ALU,
        WB_MEM,
        BRANCH,
        TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified-memory request port: controller is master, memory is slave.
interface multicycle_controller_if;
    import ctrl_pkg::*;

    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  adr_src,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type ALU function decode with a legality flag for unsupported funct3.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        unique case (funct3)
            3'b000:  alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ctrl = ALU_AND;
            3'b110:  alu_ctrl = ALU_OR;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM sequencing a one-ALU, one-memory RISC-V datapath.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7_5,
    input  logic                     zero,
    multicycle_controller_if.master  mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     pc_src,
    output logic                     reg_write,
    output logic                     result_src,
    output logic                     alu_src,
    output logic [2:0]               alu_ctrl,
    output logic [1:0]               imm_src,
    output logic                     illegal,
    output logic [CNT_W-1:0]         instr_count
);

    state_t     state, state_n;
    logic [2:0] r_ctrl;
    logic       r_legal;
    logic       retire;
    logic       req, we, adr;
    logic       is_r, is_addi, is_mem, is_br;

    alu_decoder u_alu_dec (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (r_ctrl),
        .legal    (r_legal)
    );

    assign is_r    = (opcode == OP_R) && r_legal;
    assign is_addi = (opcode == OP_ADDI) && (funct3 == 3'b000);
    assign is_mem  = ((opcode == OP_LOAD) || (opcode == OP_STORE))
                     && (funct3 == 3'b010);
    assign is_br   = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_n;
    end

    // Strobes are gated by rst so a pending request drops immediately.
    always_comb begin
        state_n    = state;
        req        = 1'b0;
        we         = 1'b0;
        adr        = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        result_src = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_n  = DECODE;
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        is_r:    state_n = EXEC_R;
                        is_addi: state_n = EXEC_I;
                        is_mem:  state_n = MEM_ADR;
                        is_br:   state_n = BRANCH;
                        default: state_n = TRAP;
                    endcase
                end
                EXEC_R: begin
                    alu_ctrl = r_ctrl;
                    state_n  = WB_ALU;
                end
                EXEC_I: begin
                    alu_src = 1'b1;
                    state_n = WB_ALU;
                end
                WB_ALU: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_n   = FETCH;
                end
                MEM_ADR: begin
                    alu_src = 1'b1;
                    if (opcode == OP_STORE) begin
                        imm_src = IMM_S;
                        state_n = MEM_WR;
                    end else begin
                        state_n = MEM_RD;
                    end
                end
                MEM_RD: begin
                    req = 1'b1;
                    adr = 1'b1;
                    if (mem.mem_ready) state_n = WB_MEM;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    result_src = 1'b1;
                    retire     = 1'b1;
                    state_n    = FETCH;
                end
                MEM_WR: begin
                    req = 1'b1;
                    we  = 1'b1;
                    adr = 1'b1;
                    if (mem.mem_ready) begin
                        retire  = 1'b1;
                        state_n = FETCH;
                    end
                end
                BRANCH: begin
                    alu_ctrl = ALU_SUB;
                    imm_src  = IMM_B;
                    pc_src   = 1'b1;
                    pc_write = funct3[0] ? ~zero : zero;
                    retire   = 1'b1;
                    state_n  = FETCH;
                end
                TRAP: begin
                    illegal = 1'b1;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;
    assign mem.adr_src = adr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (retire && (instr_count != '1)) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with hand-built strobe patterns.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        rdy;

    logic        ir_write, pc_write, pc_src, reg_write, result_src;
    logic        alu_src, illegal;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic [31:0] instr_count;

    logic        s_ir_write, s_pc_write, s_pc_src, s_reg_write;
    logic        s_result_src, s_alu_src, s_illegal;
    logic [2:0]  s_alu_ctrl;
    logic [1:0]  s_imm_src;
    logic [3:0]  s_count;

    int n_vec = 0;
    int n_err = 0;

    multicycle_controller_if mif ();
    multicycle_controller_if sif ();

    assign mif.mem_ready = rdy;
    assign sif.mem_ready = rdy;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem(mif.master),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .result_src(result_src),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .illegal(illegal), .instr_count(instr_count)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem(sif.master),
        .ir_write(s_ir_write), .pc_write(s_pc_write), .pc_src(s_pc_src),
        .reg_write(s_reg_write), .result_src(s_result_src),
        .alu_src(s_alu_src), .alu_ctrl(s_alu_ctrl), .imm_src(s_imm_src),
        .illegal(s_illegal), .instr_count(s_count)
    );

    // {req,we,adr} {irw,pcw,pcs} {rw,rs,as} alu_ctrl imm_src illegal
    logic [14:0] sig;
    assign sig = {mif.mem_req, mif.mem_we, mif.adr_src,
                  ir_write, pc_write, pc_src,
                  reg_write, result_src, alu_src,
                  alu_ctrl, imm_src, illegal};

    localparam logic [14:0] P_IDLE  = 15'd0;
    localparam logic [14:0] P_FETCH = {3'b100, 3'b110, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [14:0] P_FWAIT = {3'b100, 3'b000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [14:0] P_EXI   = {3'b000, 3'b000, 3'b001, 3'b000, 2'b00, 1'b0};
    localparam logic [14:0] P_SUB   = {3'b000, 3'b000, 3'b000, 3'b001, 2'b00, 1'b0};
    localparam logic [14:0] P_AND   = {3'b000, 3'b000, 3'b000, 3'b010, 2'b00, 1'b0};
    localparam logic [14:0] P_OR    = {3'b000, 3'b000, 3'b000, 3'b011, 2'b00, 1'b0};
    localparam logic [14:0] P_WBA   = {3'b000, 3'b000, 3'b100, 3'b000, 2'b00, 1'b0};
    localparam logic [14:0] P_ADRS  = {3'b000, 3'b000, 3'b001, 3'b000, 2'b01, 1'b0};
    localparam logic [14:0] P_MRD   = {3'b101, 3'b000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [14:0] P_WBM   = {3'b000, 3'b000, 3'b110, 3'b000, 2'b00, 1'b0};
    localparam logic [14:0] P_MWR   = {3'b111, 3'b000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [14:0] P_BR_T  = {3'b000, 3'b011, 3'b000, 3'b001, 2'b10, 1'b0};
    localparam logic [14:0] P_BR_N  = {3'b000, 3'b001, 3'b000, 3'b001, 2'b10, 1'b0};
    localparam logic [14:0] P_TRAP  = 15'd1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs set just after a rising edge; outputs sampled on the falling edge.
    task automatic step(input string tag, input logic r, input logic z,
                        input logic [14:0] exp);
        rdy  = r;
        zero = z;
        @(negedge clk);
        chk(tag, {17'd0, sig}, {17'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                         input logic f75);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f75;
    endtask

    task automatic addi(input string tag);
        instr(OP_ADDI, 3'b000, 1'b0);
        step({tag, "_f"}, 1'b1, 1'b0, P_FETCH);
        step({tag, "_d"}, 1'b1, 1'b0, P_IDLE);
        step({tag, "_x"}, 1'b1, 1'b0, P_EXI);
        step({tag, "_w"}, 1'b1, 1'b0, P_WBA);
    endtask

    task automatic branch(input string tag, input logic [2:0] f3,
                          input logic z, input logic [14:0] exp);
        instr(OP_BRANCH, f3, 1'b0);
        step({tag, "_f"}, 1'b1, z, P_FETCH);
        step({tag, "_d"}, 1'b1, z, P_IDLE);
        step({tag, "_b"}, 1'b1, z, exp);
    endtask

    task automatic rtype(input string tag, input logic [2:0] f3,
                         input logic f75, input logic [14:0] exp);
        instr(OP_R, f3, f75);
        step({tag, "_f"}, 1'b1, 1'b0, P_FETCH);
        step({tag, "_d"}, 1'b1, 1'b0, P_IDLE);
        step({tag, "_x"}, 1'b1, 1'b0, exp);
        step({tag, "_w"}, 1'b1, 1'b0, P_WBA);
    endtask

    initial begin
        rst  = 1'b1;
        rdy  = 1'b0;
        zero = 1'b0;
        instr(7'd0, 3'd0, 1'b0);

        @(negedge clk);
        chk("rst_sig", {17'd0, sig}, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        addi("addi");
        chk("addi_cnt", instr_count, 32'd1);

        instr(OP_LOAD, 3'b010, 1'b0);
        step("lw_f", 1'b1, 1'b0, P_FETCH);
        step("lw_d", 1'b1, 1'b0, P_IDLE);
        step("lw_a", 1'b1, 1'b0, P_EXI);
        for (int i = 0; i < 3; i++) step("lw_rw", 1'b0, 1'b0, P_MRD);
        step("lw_r", 1'b1, 1'b0, P_MRD);
        chk("lw_cnt_mid", instr_count, 32'd1);
        step("lw_w", 1'b1, 1'b0, P_WBM);
        chk("lw_cnt", instr_count, 32'd2);

        instr(OP_STORE, 3'b010, 1'b0);
        step("sw_f", 1'b1, 1'b0, P_FETCH);
        step("sw_d", 1'b1, 1'b0, P_IDLE);
        step("sw_a", 1'b1, 1'b0, P_ADRS);
        step("sw_ww", 1'b0, 1'b0, P_MWR);
        step("sw_w", 1'b1, 1'b0, P_MWR);
        chk("sw_cnt", instr_count, 32'd3);

        branch("bne_z0", 3'b001, 1'b0, P_BR_T);
        branch("bne_z1", 3'b001, 1'b1, P_BR_N);
        branch("beq_z0", 3'b000, 1'b0, P_BR_N);
        branch("beq_z1", 3'b000, 1'b1, P_BR_T);
        chk("br_cnt", instr_count, 32'd7);

        rtype("sub", 3'b000, 1'b1, P_SUB);
        rtype("or", 3'b110, 1'b0, P_OR);
        rtype("and", 3'b111, 1'b0, P_AND);
        chk("r_cnt", instr_count, 32'd10);

        instr(OP_R, 3'b001, 1'b0);
        step("ill_f", 1'b1, 1'b0, P_FETCH);
        step("ill_d", 1'b1, 1'b0, P_IDLE);
        for (int i = 0; i < 11; i++)
            step("trap", i[0], i[1], P_TRAP);
        chk("trap_cnt", instr_count, 32'd10);

        rst = 1'b1;
        #1;
        chk("rst2_sig", {17'd0, sig}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        instr(OP_ADDI, 3'b000, 1'b0);
        step("fw", 1'b0, 1'b0, P_FWAIT);
        rdy = 1'b0;
        #2;
        chk("pre_rst_req", {31'd0, mif.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_cnt2", instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 1; k <= 17; k++) begin
            addi("sat");
            if (k == 15) chk("sat15", {28'd0, s_count}, 32'd15);
        end
        chk("sat_big", instr_count, 32'd17);
        chk("sat_small", {28'd0, s_count}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
